// File: rtl/coin_credit_frontend.sv
// coin_credit_frontend
// Front end of the food-seller controller. Raw panel contacts are synchronised,
// debounced and turned into single-cycle event pulses. Those pulses drive a
// small credit FSM that collects coins and offers one order per purchase to the
// main FSM over a valid/ready handshake. It can also issue a one-cycle refund strobe.

module coin_credit_frontend #(
    parameter int DEB_CYCLES = 4,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 99,
    parameter int PRICE0     = 10,
    parameter int PRICE1     = 15,
    parameter int PRICE2     = 20,
    parameter int PRICE3     = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin5_raw,
    input  logic                coin10_raw,
    input  logic                buy_raw,
    input  logic                cancel_raw,
    input  logic [1:0]          sel,
    output logic                order_valid,
    input  logic                order_ready,
    output logic [1:0]          order_item,
    output logic [CREDIT_W-1:0] order_change,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int NUM_IN     = 4;
    localparam int IDX_COIN5  = 0;
    localparam int IDX_COIN10 = 1;
    localparam int IDX_BUY    = 2;
    localparam int IDX_CANCEL = 3;

    // The run counter only has to reach DEB_CYCLES-1; the flip happens on the next differing sample.
    localparam int                  CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    localparam logic [CREDIT_W-1:0] COIN5_VAL  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] COIN10_VAL = CREDIT_W'(10);
    // The limit is kept one bit wider so that the overflow test cannot wrap.
    localparam logic [CREDIT_W:0]   MAX_SUM    = (CREDIT_W + 1)'(MAX_CREDIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OFFER   = 2'd2,
        S_REFUND  = 2'd3
    } state_t;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] item);
        case (item)
            2'd0:    return CREDIT_W'(PRICE0);
            2'd1:    return CREDIT_W'(PRICE1);
            2'd2:    return CREDIT_W'(PRICE2);
            default: return CREDIT_W'(PRICE3);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Input conditioning: sync -> debounce -> rising-edge pulse
    // ------------------------------------------------------------------
    logic [NUM_IN-1:0]            raw_vec;
    logic [NUM_IN-1:0]            sync1;
    logic [NUM_IN-1:0]            sync2;
    logic [NUM_IN-1:0]            level;
    logic [NUM_IN-1:0]            level_d;
    logic [NUM_IN-1:0]            pulse;
    logic [NUM_IN-1:0][CNT_W-1:0] deb_cnt;

    assign raw_vec = {cancel_raw, buy_raw, coin10_raw, coin5_raw};

    // Two-flop synchroniser for the asynchronous panel contacts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            // NOTE: non-blocking assignments make sync2 take the old sync1, so this is really two flops.
            sync1 <= raw_vec;
            sync2 <= sync1;
        end
    end

    // Debounce: a level flips only after DEB_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= '0;
            // NOTE: these counters are control state, not a data store, so they are reset too.
            deb_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_MAX) begin
                    level[i]   <= ~level[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // One-cycle pulse on each debounced rising edge; falling edges are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= '0;
            pulse   <= '0;
        end else begin
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

    // ------------------------------------------------------------------
    // Event arbitration: cancel > buy > coin10 > coin5
    // ------------------------------------------------------------------
    logic                c5_p;
    logic                c10_p;
    logic                buy_p;
    logic                cancel_p;
    logic                coin_win;
    logic                coin_dropped;
    logic [CREDIT_W-1:0] coin_value;
    logic [CREDIT_W:0]   credit_sum;
    logic [CREDIT_W-1:0] price;

    assign c5_p       = pulse[IDX_COIN5];
    assign c10_p      = pulse[IDX_COIN10];
    assign buy_p      = pulse[IDX_BUY];
    assign cancel_p   = pulse[IDX_CANCEL];
    assign credit_sum = {1'b0, credit} + {1'b0, coin_value};
    assign price      = price_of(sel);

    // Select the winning coin, if any, and flag coin pulses that lost arbitration.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        coin_win     = 1'b0;
        coin_dropped = 1'b0;
        coin_value   = '0;
        if (cancel_p || buy_p) begin
            coin_dropped = c5_p | c10_p;
        end else if (c10_p) begin
            coin_win     = 1'b1;
            coin_value   = COIN10_VAL;
            coin_dropped = c5_p;
        end else if (c5_p) begin
            coin_win     = 1'b1;
            coin_value   = COIN5_VAL;
        end
    end

    // ------------------------------------------------------------------
    // Credit FSM
    // ------------------------------------------------------------------
    state_t              state;
    state_t              state_next;
    logic [CREDIT_W-1:0] credit_next;
    logic [CREDIT_W-1:0] change_next;
    logic [CREDIT_W-1:0] refund_amt_next;
    logic [1:0]          item_next;
    logic                valid_next;
    logic                refund_next;
    logic                reject_next;

    // Next-state and next-output logic; everything defaults to hold or idle.
    always_comb begin
        state_next      = state;
        credit_next     = credit;
        valid_next      = order_valid;
        item_next       = order_item;
        change_next     = order_change;
        refund_next     = 1'b0;
        refund_amt_next = refund_amt;
        reject_next     = coin_dropped;

        unique case (state)
            S_IDLE: begin
                // Buy and cancel mean nothing without credit.
                if (coin_win) begin
                    credit_next = coin_value;
                    state_next  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (cancel_p) begin
                    refund_next     = 1'b1;
                    refund_amt_next = credit;
                    state_next      = S_REFUND;
                end else if (buy_p) begin
                    if (credit >= price) begin
                        item_next   = sel;
                        change_next = credit - price;
                        valid_next  = 1'b1;
                        state_next  = S_OFFER;
                    end
                end else if (coin_win) begin
                    if (credit_sum > MAX_SUM) begin
                        reject_next = 1'b1;
                    end else begin
                        credit_next = credit_sum[CREDIT_W-1:0];
                    end
                end
            end
            S_OFFER: begin
                // The payload is frozen; only the handshake can move us on.
                if (coin_win) begin
                    reject_next = 1'b1;
                end
                if (order_valid && order_ready) begin
                    valid_next  = 1'b0;
                    credit_next = '0;
                    state_next  = S_IDLE;
                end
            end
            S_REFUND: begin
                // The refund strobe is high for this cycle only.
                if (coin_win) begin
                    reject_next = 1'b1;
                end
                credit_next = '0;
                state_next  = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight order or refund.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            credit       <= '0;
            order_valid  <= 1'b0;
            order_item   <= '0;
            order_change <= '0;
            refund_valid <= 1'b0;
            refund_amt   <= '0;
            coin_reject  <= 1'b0;
        end else begin
            state        <= state_next;
            credit       <= credit_next;
            order_valid  <= valid_next;
            order_item   <= item_next;
            order_change <= change_next;
            refund_valid <= refund_next;
            refund_amt   <= refund_amt_next;
            coin_reject  <= reject_next;
        end
    end

endmodule

// File: tb/tb_coin_credit_frontend.sv
// Testbench for coin_credit_frontend: directed sequences, a vector table, and
// random actions checked against an action-level model of the credit rules.
`timescale 1ns/1ps

module tb_coin_credit_frontend;

    localparam int CW = 8;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          coin5_raw   = 1'b0;
    logic          coin10_raw  = 1'b0;
    logic          buy_raw     = 1'b0;
    logic          cancel_raw  = 1'b0;
    logic [1:0]    sel         = 2'd0;
    logic          order_ready = 1'b0;
    logic          order_valid;
    logic [1:0]    order_item;
    logic [CW-1:0] order_change;
    logic          refund_valid;
    logic [CW-1:0] refund_amt;
    logic [CW-1:0] credit;
    logic          coin_reject;

    coin_credit_frontend dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin5_raw    (coin5_raw),
        .coin10_raw   (coin10_raw),
        .buy_raw      (buy_raw),
        .cancel_raw   (cancel_raw),
        .sel          (sel),
        .order_valid  (order_valid),
        .order_ready  (order_ready),
        .order_item   (order_item),
        .order_change (order_change),
        .refund_valid (refund_valid),
        .refund_amt   (refund_amt),
        .credit       (credit),
        .coin_reject  (coin_reject)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Strobe monitor: counts strobe cycles, sampled on the falling edge.
    int refund_cnt  = 0;
    int reject_cnt  = 0;
    int last_refund = 0;
    always @(negedge clk) begin
        if (refund_valid) begin
            refund_cnt  = refund_cnt + 1;
            last_refund = int'(refund_amt);
        end
        if (coin_reject) reject_cnt = reject_cnt + 1;
    end

    typedef enum int {A_C5, A_C10, A_BUY, A_CANCEL, A_BUYCAN, A_C5C10, A_C5BUY, A_ACCEPT} act_e;

    typedef struct {
        act_e act;
        int   sel;
        int   exp_credit;
        int   exp_valid;
        int   exp_item;
        int   exp_change;
        int   exp_refunds;
        int   exp_last;
        int   exp_rejects;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(act_e a, int s, int cr, int vl, int it, int ch, int rf, int lr, int rj);
        vec_t r;
        r.act = a; r.sel = s; r.exp_credit = cr; r.exp_valid = vl; r.exp_item = it;
        r.exp_change = ch; r.exp_refunds = rf; r.exp_last = lr; r.exp_rejects = rj;
        return r;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one panel action long enough to debounce, release, and let it settle.
    task automatic do_action(input act_e a, input int s);
        sel = 2'(s);
        if (a == A_ACCEPT) begin
            order_ready = 1'b1;
            tick(1);
            order_ready = 1'b0;
            tick(3);
        end else begin
            coin5_raw  = (a == A_C5)  || (a == A_C5C10) || (a == A_C5BUY);
            coin10_raw = (a == A_C10) || (a == A_C5C10);
            buy_raw    = (a == A_BUY) || (a == A_BUYCAN) || (a == A_C5BUY);
            cancel_raw = (a == A_CANCEL) || (a == A_BUYCAN);
            tick(8);
            coin5_raw  = 1'b0;
            coin10_raw = 1'b0;
            buy_raw    = 1'b0;
            cancel_raw = 1'b0;
            tick(10);
        end
        #1;
    endtask

    // Action-level reference model of the credit rules.
    int m_credit, m_item, m_change, m_refunds, m_last_refund, m_rejects;
    bit m_offer;

    function automatic int item_price(int s);
        case (s)
            0:       return 10;
            1:       return 15;
            2:       return 20;
            default: return 25;
        endcase
    endfunction

    task automatic model_step(input act_e a, input int s);
        bit c5, c10, b, cn, rej;
        int val;
        if (a == A_ACCEPT) begin
            if (m_offer) begin
                m_offer  = 1'b0;
                m_credit = 0;
            end
            return;
        end
        c5  = (a == A_C5)  || (a == A_C5C10) || (a == A_C5BUY);
        c10 = (a == A_C10) || (a == A_C5C10);
        b   = (a == A_BUY) || (a == A_BUYCAN) || (a == A_C5BUY);
        cn  = (a == A_CANCEL) || (a == A_BUYCAN);
        rej = 1'b0;
        if (cn || b) begin
            rej = c5 || c10;
            if (cn) begin
                if (!m_offer && m_credit > 0) begin
                    m_refunds++;
                    m_last_refund = m_credit;
                    m_credit      = 0;
                end
            end else if (!m_offer && m_credit > 0 && m_credit >= item_price(s)) begin
                m_offer  = 1'b1;
                m_item   = s;
                m_change = m_credit - item_price(s);
            end
        end else if (c5 || c10) begin
            val = c10 ? 10 : 5;
            if (c5 && c10)                 rej = 1'b1;
            if (m_offer)                   rej = 1'b1;
            else if (m_credit == 0)        m_credit = val;
            else if (m_credit + val > 99)  rej = 1'b1;
            else                           m_credit = m_credit + val;
        end
        if (rej) m_rejects++;
    endtask

    initial begin
        int base_ref, base_rej, r;
        act_e a;
        int s;

        // ---------------- Reset state ----------------
        tick(2);
        #1;
        check("rst order_valid",  int'(order_valid),  0);
        check("rst order_item",   int'(order_item),   0);
        check("rst order_change", int'(order_change), 0);
        check("rst refund_valid", int'(refund_valid), 0);
        check("rst refund_amt",   int'(refund_amt),   0);
        check("rst credit",       int'(credit),       0);
        check("rst coin_reject",  int'(coin_reject),  0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        #1;

        // ---------------- Bounce filtering ----------------
        for (int i = 0; i < 10; i++) begin
            coin5_raw = ~coin5_raw;
            tick(1);
        end
        coin5_raw = 1'b1;
        tick(20);
        coin5_raw = 1'b0;
        tick(10);
        #1;
        check("bounce credit", int'(credit), 5);
        check("bounce rejects", reject_cnt, 0);
        coin10_raw = 1'b1;
        tick(3);
        coin10_raw = 1'b0;
        tick(12);
        #1;
        check("glitch credit", int'(credit), 5);

        // ---------------- Pulse latency ----------------
        coin10_raw = 1'b1;
        tick(7);
        #1;
        check("latency early credit", int'(credit), 5);
        tick(1);
        #1;
        check("latency credit", int'(credit), 15);
        tick(2);
        coin10_raw = 1'b0;
        tick(10);
        #1;
        do_action(A_CANCEL, 0);
        check("clear credit", int'(credit), 0);
        check("clear refund amt", last_refund, 15);
        check("clear refund count", refund_cnt, 1);

        // ---------------- Order handshake ----------------
        do_action(A_C5, 0);
        do_action(A_C10, 0);
        do_action(A_BUY, 1);
        check("offer valid",  int'(order_valid),  1);
        check("offer item",   int'(order_item),   1);
        check("offer change", int'(order_change), 0);
        check("offer credit", int'(credit),       15);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            #1;
            check($sformatf("hold%0d valid", i),  int'(order_valid),  1);
            check($sformatf("hold%0d item", i),   int'(order_item),   1);
            check($sformatf("hold%0d change", i), int'(order_change), 0);
        end
        order_ready = 1'b1;
        tick(1);
        order_ready = 1'b0;
        #1;
        check("accept valid",  int'(order_valid), 0);
        check("accept credit", int'(credit),      0);
        do_action(A_BUY, 0);
        check("idle buy valid", int'(order_valid), 0);

        // ---------------- Vector table ----------------
        tbl.push_back(v(A_BUY,    0,  0, 0, 0,  0, 0,  0, 0));
        tbl.push_back(v(A_CANCEL, 0,  0, 0, 0,  0, 0,  0, 0));
        tbl.push_back(v(A_C10,    0, 10, 0, 0,  0, 0,  0, 0));
        tbl.push_back(v(A_BUY,    3, 10, 0, 0,  0, 0,  0, 0));
        tbl.push_back(v(A_C5,     0, 15, 0, 0,  0, 0,  0, 0));
        tbl.push_back(v(A_CANCEL, 0,  0, 0, 0,  0, 1, 15, 0));
        tbl.push_back(v(A_C10,    0, 10, 0, 0,  0, 1, 15, 0));
        tbl.push_back(v(A_C5,     0, 15, 0, 0,  0, 1, 15, 0));
        tbl.push_back(v(A_BUYCAN, 0,  0, 0, 0,  0, 2, 15, 0));
        for (int k = 1; k <= 9; k++)
            tbl.push_back(v(A_C10, 0, 10 * k, 0, 0, 0, 2, 15, 0));
        tbl.push_back(v(A_C5,     0, 95, 0, 0,  0, 2, 15, 0));
        tbl.push_back(v(A_C10,    0, 95, 0, 0,  0, 2, 15, 1));
        tbl.push_back(v(A_C5,     0, 95, 0, 0,  0, 2, 15, 2));
        tbl.push_back(v(A_BUY,    3, 95, 1, 3, 70, 2, 15, 2));
        tbl.push_back(v(A_C5,     0, 95, 1, 3, 70, 2, 15, 3));
        tbl.push_back(v(A_CANCEL, 0, 95, 1, 3, 70, 2, 15, 3));
        tbl.push_back(v(A_ACCEPT, 0,  0, 0, 0,  0, 2, 15, 3));
        tbl.push_back(v(A_C5C10,  0, 10, 0, 0,  0, 2, 15, 4));
        tbl.push_back(v(A_C5,     0, 15, 0, 0,  0, 2, 15, 4));
        tbl.push_back(v(A_BUY,    2, 15, 0, 0,  0, 2, 15, 4));
        tbl.push_back(v(A_C5BUY,  1, 15, 1, 1,  0, 2, 15, 5));
        tbl.push_back(v(A_ACCEPT, 0,  0, 0, 0,  0, 2, 15, 5));

        base_ref = refund_cnt;
        base_rej = reject_cnt;
        foreach (tbl[i]) begin
            do_action(tbl[i].act, tbl[i].sel);
            check($sformatf("row%0d credit", i), int'(credit), tbl[i].exp_credit);
            check($sformatf("row%0d valid", i),  int'(order_valid), tbl[i].exp_valid);
            if (tbl[i].exp_valid != 0) begin
                check($sformatf("row%0d item", i),   int'(order_item),   tbl[i].exp_item);
                check($sformatf("row%0d change", i), int'(order_change), tbl[i].exp_change);
            end
            check($sformatf("row%0d refunds", i), refund_cnt - base_ref, tbl[i].exp_refunds);
            if (tbl[i].exp_refunds > 0)
                check($sformatf("row%0d refund amt", i), last_refund, tbl[i].exp_last);
            check($sformatf("row%0d rejects", i), reject_cnt - base_rej, tbl[i].exp_rejects);
        end

        // ---------------- Reset during OFFER ----------------
        do_action(A_C10, 0);
        do_action(A_C5, 0);
        do_action(A_BUY, 0);
        check("pre-reset valid",  int'(order_valid),  1);
        check("pre-reset change", int'(order_change), 5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset valid",  int'(order_valid), 0);
        check("async reset credit", int'(credit),      0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        #1;
        check("post-reset valid",  int'(order_valid), 0);
        check("post-reset credit", int'(credit),      0);
        do_action(A_C5, 0);
        check("post-reset coin", int'(credit), 5);

        // ---------------- Randomized against model ----------------
        m_credit = 5; m_offer = 1'b0; m_item = 0; m_change = 0;
        m_refunds = 0; m_last_refund = 0; m_rejects = 0;
        base_ref = refund_cnt;
        base_rej = reject_cnt;
        for (int it = 0; it < 150; it++) begin
            r = int'($urandom_range(0, 99));
            s = int'($urandom_range(0, 3));
            if      (r < 30) a = A_C5;
            else if (r < 55) a = A_C10;
            else if (r < 68) a = A_BUY;
            else if (r < 76) a = A_CANCEL;
            else if (r < 80) a = A_BUYCAN;
            else if (r < 85) a = A_C5C10;
            else if (r < 89) a = A_C5BUY;
            else             a = A_ACCEPT;
            do_action(a, s);
            model_step(a, s);
            check($sformatf("rnd%0d credit", it), int'(credit), m_credit);
            check($sformatf("rnd%0d valid", it),  int'(order_valid), int'(m_offer));
            if (m_offer) begin
                check($sformatf("rnd%0d item", it),   int'(order_item),   m_item);
                check($sformatf("rnd%0d change", it), int'(order_change), m_change);
            end
            check($sformatf("rnd%0d refunds", it), refund_cnt - base_ref, m_refunds);
            if (m_refunds > 0)
                check($sformatf("rnd%0d refund amt", it), last_refund, m_last_refund);
            check($sformatf("rnd%0d rejects", it), reject_cnt - base_rej, m_rejects);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
